counter_b4_checker: RTL and testbench
=====================================

COUNTER_B4_CHECKER -- requirements
Module: counter_b4_checker

Interface
REQ-001 Parameter: HALT_ON_ERR, default 0, 1 = freeze checking after the first mismatch until reset.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 chk_clk  in  1  clock; all state updates on rising edge.
REQ-004 chk_reset  in  1  synchronous active-high reset.
REQ-005 chk_enable  in  1  enable stimulus, the same value driven to the 4-bit counter.
REQ-006 chk_mode  in  2  mode stimulus: 00 = +1, 01 = -1, 10 = -3, 11 = parallel load.
REQ-007 chk_D  in  4  parallel-load data stimulus.
REQ-008 chk_Q  in  4  counter value observed from the DUT.
REQ-009 chk_load  in  1  load flag observed from the DUT.
REQ-010 chk_rco  in  1  ripple-carry-out observed from the DUT.
REQ-011 chk_err  out  1  single-cycle pulse, one per mismatching compare.
REQ-012 chk_err_code  out  3  mismatch bits: bit0 = Q, bit1 = load, bit2 = rco; valid while chk_err = 1, otherwise 0.
REQ-013 chk_err_cnt  out  8  saturating count of mismatching compares.
REQ-014 chk_synced  out  1  high while the FSM is in SYNC.

Function
REQ-015 FSM states SHALL be UNSYNC, SYNC and HALT.
REQ-016 UNSYNC -> SYNC: at the compare edge for a stimulus with enable = 1 and mode = 11.
REQ-017 SYNC -> HALT: on any mismatch when HALT_ON_ERR = 1.
REQ-018 HALT is exited only by reset.
REQ-019 Each edge outside HALT SHALL register the stimulus (enable, mode, D) and set cmp_valid.
REQ-020 At the next edge, if cmp_valid = 1, the registered stimulus SHALL be compared against chk_Q, chk_load and chk_rco; compare latency is one cycle.
REQ-021 Expected results SHALL be computed from base value P: exp_q in SYNC, chk_Q as sampled at the stimulus edge in UNSYNC.
REQ-022 Expected for enable = 0: Q = P (held), load = 0, rco = 0.
REQ-023 Expected for mode 00: Q = P+1 mod 16, load = 0, rco = 1 iff P >= 13.
REQ-024 Expected for mode 01: Q = P-1 mod 16, load = 0, rco = 1 iff P = 15.
REQ-025 Expected for mode 10: Q = P-3 mod 16, load = 0, rco = 1 iff P = 15.
REQ-026 Expected for mode 11: Q = D, load = 1, rco = 0.
REQ-027 All arithmetic is 4-bit with modulo-16 wrap: 15+1 -> 0, 0-1 -> 15, 1-3 -> 14.
REQ-028 In UNSYNC, the Q and rco compares SHALL be masked; only load SHALL be compared.
REQ-029 In SYNC, all three fields SHALL be compared; exp_q SHALL be updated to the expected Q each edge.
REQ-030 Q mismatch in SYNC with HALT_ON_ERR = 0: exp_q SHALL rebase to the observed chk_Q, so that no cascaded errors are reported.
REQ-031 chk_err and chk_err_code SHALL be registered and asserted in the cycle after the compare edge, for exactly one cycle per mismatching compare.
REQ-032 chk_err_cnt SHALL increment by 1 per mismatching compare (multiple field mismatches count once) and saturate at 255.
REQ-033 In HALT: no compares; chk_err = 0; chk_err_cnt frozen; chk_synced = 0.

Reset
REQ-034 While chk_reset = 1: state = UNSYNC, cmp_valid = 0, exp_q = 0, chk_err = 0, chk_err_code = 0, chk_err_cnt = 0, chk_synced = 0.
REQ-035 A pending compare at the reset edge SHALL be discarded.
REQ-036 Reset has priority over all other inputs.
REQ-037 The first compare after reset deassertion SHALL occur at the second edge.

Verification
REQ-038 The bench SHALL cover sync: reset, then enable = 1, mode = 11, D = 0xA -> next cycle DUT Q = 0xA, load = 1; chk_err = 0; chk_synced = 1.
REQ-039 The bench SHALL cover up-count wrap: from Q = 0xE, mode 00 for three cycles -> expected Q and rco pairs (F, 1), (0, 1), (1, 0); no error when the DUT matches.
REQ-040 The bench SHALL cover down-by-3 wrap: from Q = 0x1, mode 10 -> expected Q = 0xE, rco = 0.
REQ-041 The bench SHALL cover rebase: in SYNC, expected 6 but DUT reports 5 -> chk_err pulse, code 001, cnt = 1; next mode 00 expects 6 with no further error.
REQ-042 The bench SHALL cover halt: HALT_ON_ERR = 1, DUT load = 1 during mode 00 -> code 010, cnt = 1, state HALT; further mismatches leave cnt = 1 until reset.
REQ-043 The bench SHALL cover saturation and reset: 300 consecutive mismatches -> cnt = 255; reset mid-run -> all outputs 0 at the next cycle.

Source files
------------

// File: rtl/counter_b4_checker.sv
// Scoreboard checker for a 4-bit up/down/load counter.
// Predicts Q/load/rco one cycle after each stimulus and flags mismatches.
module counter_b4_checker #(
  parameter bit HALT_ON_ERR = 1'b0
) (
  input  logic       chk_clk,
  input  logic       chk_reset,
  input  logic       chk_enable,
  input  logic [1:0] chk_mode,
  input  logic [3:0] chk_D,
  input  logic [3:0] chk_Q,
  input  logic       chk_load,
  input  logic       chk_rco,
  output logic       chk_err,
  output logic [2:0] chk_err_code,
  output logic [7:0] chk_err_cnt,
  output logic       chk_synced
);

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    SYNC   = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       cmp_valid_q, cmp_valid_d;
  logic       en_q, en_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] data_q, data_d;
  logic [3:0] exp_q, exp_d;
  logic       err_q, err_d;
  logic [2:0] code_q, code_d;
  logic [7:0] cnt_q, cnt_d;

  logic [3:0] calc_q;
  logic       calc_load;
  logic       calc_rco;
  logic [2:0] mis;
  logic       do_cmp;
  logic       hit;

  // exp_q holds the base value P of the registered stimulus
  always_comb begin
    calc_q    = exp_q;
    calc_load = 1'b0;
    calc_rco  = 1'b0;
    if (en_q) begin
      unique case (mode_q)
        2'b00: begin
          calc_q   = exp_q + 4'd1;
          calc_rco = (exp_q >= 4'd13);
        end
        2'b01: begin
          calc_q   = exp_q - 4'd1;
          calc_rco = (exp_q == 4'd15);
        end
        2'b10: begin
          calc_q   = exp_q - 4'd3;
          calc_rco = (exp_q == 4'd15);
        end
        2'b11: begin
          calc_q    = data_q;
          calc_load = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    do_cmp = cmp_valid_q && (state_q != HALT);
    mis    = {chk_rco != calc_rco, chk_load != calc_load, chk_Q != calc_q};
    if (state_q == UNSYNC) begin
      mis[0] = 1'b0;
      mis[2] = 1'b0;
    end
    if (!do_cmp) begin
      mis = 3'b000;
    end
    hit = |mis;

    state_d = state_q;
    case (state_q)
      UNSYNC: if (do_cmp && en_q && mode_q == 2'b11) state_d = SYNC;
      SYNC:   if (hit && HALT_ON_ERR) state_d = HALT;
      default: state_d = state_q;
    endcase

    // A Q mismatch rebases onto the observed value to avoid cascades
    exp_d = exp_q;
    if (state_d == SYNC) begin
      exp_d = (state_q == SYNC && mis[0]) ? chk_Q : calc_q;
    end else if (state_d == UNSYNC) begin
      exp_d = chk_Q;
    end

    en_d        = en_q;
    mode_d      = mode_q;
    data_d      = data_q;
    cmp_valid_d = 1'b0;
    if (state_q != HALT) begin
      en_d        = chk_enable;
      mode_d      = chk_mode;
      data_d      = chk_D;
      cmp_valid_d = 1'b1;
    end

    err_d  = hit;
    code_d = mis;
    cnt_d  = cnt_q;
    if (hit && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge chk_clk) begin
    if (chk_reset) begin
      state_q     <= UNSYNC;
      cmp_valid_q <= 1'b0;
      en_q        <= 1'b0;
      mode_q      <= 2'b00;
      data_q      <= 4'd0;
      exp_q       <= 4'd0;
      err_q       <= 1'b0;
      code_q      <= 3'b000;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      cmp_valid_q <= cmp_valid_d;
      en_q        <= en_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      exp_q       <= exp_d;
      err_q       <= err_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
    end
  end

  assign chk_err      = err_q;
  assign chk_err_code = code_q;
  assign chk_err_cnt  = cnt_q;
  assign chk_synced   = (state_q == SYNC);

endmodule

// File: tb/tb_counter_b4_checker.sv
// Randomized bench for counter_b4_checker with a behavioural counter
// and checker model; both HALT_ON_ERR settings run side by side.
module tb_counter_b4_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] d = 4'd0;
  logic [3:0] q = 4'd0;
  logic       ld = 1'b0;
  logic       rc = 1'b0;

  logic       err0, err1;
  logic [2:0] code0, code1;
  logic [7:0] cnt0, cnt1;
  logic       syn0, syn1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_b4_checker #(.HALT_ON_ERR(1'b0)) dut0 (
    .chk_clk(clk), .chk_reset(rst), .chk_enable(en), .chk_mode(mode),
    .chk_D(d), .chk_Q(q), .chk_load(ld), .chk_rco(rc),
    .chk_err(err0), .chk_err_code(code0), .chk_err_cnt(cnt0),
    .chk_synced(syn0)
  );

  counter_b4_checker #(.HALT_ON_ERR(1'b1)) dut1 (
    .chk_clk(clk), .chk_reset(rst), .chk_enable(en), .chk_mode(mode),
    .chk_D(d), .chk_Q(q), .chk_load(ld), .chk_rco(rc),
    .chk_err(err1), .chk_err_code(code1), .chk_err_cnt(cnt1),
    .chk_synced(syn1)
  );

  // Counter rule: returns {Q, load, rco} from base p
  function automatic logic [5:0] exp_f(input logic [3:0] p, input logic e,
                                       input logic [1:0] m,
                                       input logic [3:0] dd);
    int pi;
    logic [3:0] nq;
    pi = int'(p);
    if (!e) return {p, 2'b00};
    case (m)
      2'd0: begin nq = 4'((pi + 1) % 16); return {nq, 1'b0, pi >= 13}; end
      2'd1: begin nq = 4'((pi + 15) % 16); return {nq, 1'b0, pi == 15}; end
      2'd2: begin nq = 4'((pi + 13) % 16); return {nq, 1'b0, pi == 15}; end
      default: return {dd, 2'b10};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Behavioural counter that the checker is watching
  logic [3:0] ctr = 4'd0;
  logic       ctr_ld = 1'b0;
  logic       ctr_rc = 1'b0;
  logic       p_rst = 1'b1;
  logic       p_en = 1'b0;
  logic [1:0] p_mode = 2'b00;
  logic [3:0] p_d = 4'd0;

  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [3:0] dd, input logic [3:0] qf,
                      input logic lf, input logic rf);
    logic [5:0] o;
    @(negedge clk);
    if (p_rst) begin
      ctr = 4'd0; ctr_ld = 1'b0; ctr_rc = 1'b0;
    end else begin
      o = exp_f(ctr, p_en, p_mode, p_d);
      ctr = o[5:2]; ctr_ld = o[1]; ctr_rc = o[0];
    end
    ctr = ctr ^ qf;
    q = ctr; ld = ctr_ld ^ lf; rc = ctr_rc ^ rf;
    rst = r; en = e; mode = m; d = dd;
    p_rst = r; p_en = e; p_mode = m; p_d = dd;
  endtask

  // Checker model: state 0 unsynced, 1 synced, 2 halted
  int         ms[2];
  bit         mp[2];
  logic       men[2];
  logic [1:0] mm[2];
  logic [3:0] mdd[2];
  logic [3:0] mb[2];
  logic       merr[2];
  logic [2:0] mcode[2];
  int         mcnt[2];
  bit         live = 1'b0;
  logic [5:0] t_e;
  logic [2:0] t_mi;
  int         t_ns;
  logic [3:0] t_nb;

  always @(posedge clk) begin
    if (rst) live <= 1'b1;
    for (int h = 0; h < 2; h++) begin
      if (rst) begin
        ms[h] <= 0; mp[h] <= 1'b0; mb[h] <= 4'd0;
        merr[h] <= 1'b0; mcode[h] <= 3'b000; mcnt[h] <= 0;
      end else begin
        t_mi = 3'b000;
        t_ns = ms[h];
        t_e = 6'd0;
        if (ms[h] != 2 && mp[h]) begin
          t_e = exp_f(mb[h], men[h], mm[h], mdd[h]);
          t_mi = {rc != t_e[0], ld != t_e[1], q != t_e[5:2]};
          if (ms[h] == 0) t_mi = t_mi & 3'b010;
          if (ms[h] == 0 && men[h] && mm[h] == 2'd3) t_ns = 1;
          if (ms[h] == 1 && t_mi != 0 && h == 1) t_ns = 2;
        end
        // Next base is the observed Q, except right after syncing
        t_nb = (ms[h] == 0 && t_ns == 1) ? t_e[5:2] : q;
        if (ms[h] != 2) begin
          mp[h] <= 1'b1; men[h] <= en; mm[h] <= mode;
          mdd[h] <= d; mb[h] <= t_nb;
        end else begin
          mp[h] <= 1'b0;
        end
        ms[h] <= t_ns;
        merr[h] <= (t_mi != 0);
        mcode[h] <= t_mi;
        if (t_mi != 0 && mcnt[h] < 255) mcnt[h] <= mcnt[h] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      for (int h = 0; h < 2; h++) begin
        chk($sformatf("err%0d", h), h ? err1 : err0, merr[h]);
        chk($sformatf("code%0d", h), h ? code1 : code0, mcode[h]);
        chk($sformatf("cnt%0d", h), h ? cnt1 : cnt0, mcnt[h]);
        chk($sformatf("synced%0d", h), h ? syn1 : syn0, ms[h] == 1);
      end
    end
  end

  initial begin
    chk("rule_up_E", exp_f(4'hE, 1'b1, 2'd0, 4'd0), {4'hF, 2'b01});
    chk("rule_up_F", exp_f(4'hF, 1'b1, 2'd0, 4'd0), {4'h0, 2'b01});
    chk("rule_up_0", exp_f(4'h0, 1'b1, 2'd0, 4'd0), {4'h1, 2'b00});
    chk("rule_dn_0", exp_f(4'h0, 1'b1, 2'd1, 4'd0), {4'hF, 2'b00});
    chk("rule_m3_1", exp_f(4'h1, 1'b1, 2'd2, 4'd0), {4'hE, 2'b00});
    chk("rule_m3_F", exp_f(4'hF, 1'b1, 2'd2, 4'd0), {4'hC, 2'b01});
    chk("rule_load", exp_f(4'h3, 1'b1, 2'd3, 4'h9), {4'h9, 2'b10});
    chk("rule_hold", exp_f(4'h7, 1'b0, 2'd0, 4'h9), {4'h7, 2'b00});

    // Sync and wrap-around
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 4'hA, 0, 0, 0);
    chk("rst_err", err0, 1'b0);
    chk("rst_cnt", cnt0, 8'd0);
    chk("rst_syn", syn0, 1'b0);
    step(0, 1, 3, 4'hE, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("sync_err", err0, 1'b0);
    chk("sync_syn", syn0, 1'b1);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("wrap_q_F", {q, rc}, {4'hF, 1'b1});
    step(0, 1, 0, 0, 0, 0, 0);
    chk("wrap_q_0", {q, rc}, {4'h0, 1'b1});
    step(0, 1, 2, 0, 0, 0, 0);
    chk("wrap_q_1", {q, rc}, {4'h1, 1'b0});
    step(0, 0, 0, 0, 0, 0, 0);
    chk("dn3_q_E", {q, rc}, {4'hE, 1'b0});
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_cnt", cnt0, 8'd0);
    chk("wrap_syn", syn0, 1'b1);

    // Rebase after a Q mismatch
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 4'h5, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 4'h3, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rb_err", err0, 1'b1);
    chk("rb_code", code0, 3'b001);
    chk("rb_cnt", cnt0, 8'd1);
    chk("rb_halt_syn", syn1, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rb_err2", err0, 1'b0);
    chk("rb_cnt2", cnt0, 8'd1);

    // Halt on a load mismatch
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 4'h3, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    chk("halt_code", code1, 3'b010);
    chk("halt_cnt", cnt1, 8'd1);
    chk("halt_syn", syn1, 1'b0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 1, 0);
    chk("halt_cnt2", cnt1, 8'd1);
    chk("halt_err2", err1, 1'b0);
    chk("nohalt_cnt", cnt0, 8'd6);

    // Saturation, then reset mid-run
    for (int i = 0; i < 300; i++) step(0, 1, 0, 0, 0, 1, 0);
    chk("sat_cnt", cnt0, 8'd255);
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    chk("mid_rst", {err0, code0, cnt0, syn0}, 13'd0);
    chk("mid_rst1", {err1, code1, cnt1, syn1}, 13'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 7) != 0,
           2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 29) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
